dmem_arbiter: RTL and testbench

Shares one single-ported, fixed-latency data memory between the CPU's MEM stage and a debug/loader port. Round-robin arbitration; each access is sequenced through a small FSM. Stalls the pipeline while a CPU access is pending. Sits between EX_MEM outputs and the data memory, with its stall OR-ed into the pipeline-wide stall.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types for the data-memory arbiter: the access FSM state
//   encoding and the grant encoding used by dmem_arbiter and rr_arb2.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin picker.
//   req[0] = CPU, req[1] = debug.
//   last_gnt : requester granted most recently (GNT_CPU / GNT_DBG)
//   gnt      : chosen requester; only meaningful when req != 0
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt
);

    always_comb begin
        gnt = GNT_CPU;
        case (req)
            2'b10:   gnt = GNT_DBG;
            // Tie: hand the slot to whoever did not have it last time.
            2'b11:   gnt = (last_gnt == GNT_DBG) ? GNT_CPU : GNT_DBG;
            default: gnt = GNT_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-ported, fixed-latency data memory between the CPU
//   MEM stage and a debug/loader port. Each access runs IDLE -> ACCESS
//   (MEM_LAT cycles, strobe in the first) -> DONE (completion) -> IDLE.
//
//   Build option: DMEM_ARB_DBG_EN
//     defined   : debug port functional, round-robin arbitration.
//     undefined : dbg_* inputs ignored, dbg_ack_o/dbg_rdata_o tied 0,
//                 grant is always CPU, CPU timing unchanged.
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     cpu_req/we/addr/wdata CPU access request (held until done)
//     cpu_rdata_o           CPU read data (live in DONE, else held)
//     cpu_stall_o           pipeline hold, combinational on cpu_req_i
//     dbg_req/we/addr/wdata debug request (held until dbg_ack_o)
//     dbg_rdata_o, dbg_ack_o debug read data / one-cycle completion
//     mem_en/we/addr/wdata  one-cycle access strobe to memory
//     mem_rdata_i           read data, valid MEM_LAT cycles after mem_en_o
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_q;
    logic              gnt_next;
    logic              start;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              en_q;
    logic [DATA_W-1:0] cpu_hold;
    logic              cpu_done;

`ifdef DMEM_ARB_DBG_EN
    logic              last_gnt;
    logic [DATA_W-1:0] dbg_hold;
    logic              dbg_done;

    rr_arb2 u_rr_arb2 (
        .req      ({dbg_req_i, cpu_req_i}),
        .last_gnt (last_gnt),
        .gnt      (gnt_next)
    );

    assign start = cpu_req_i | dbg_req_i;

    always_comb begin
        sel_we    = cpu_we_i;
        sel_addr  = cpu_addr_i;
        sel_wdata = cpu_wdata_i;
        if (gnt_next == GNT_DBG) begin
            sel_we    = dbg_we_i;
            sel_addr  = dbg_addr_i;
            sel_wdata = dbg_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt <= GNT_DBG;   // CPU wins the first tie after reset
            dbg_hold <= '0;
        end else begin
            if (state == IDLE && start)
                last_gnt <= gnt_next;
            if (dbg_done && !we_q)
                dbg_hold <= mem_rdata_i;
        end
    end

    assign dbg_done    = (state == DONE) && (gnt_q == GNT_DBG);
    assign dbg_ack_o   = dbg_done;
    assign dbg_rdata_o = dbg_done ? mem_rdata_i : dbg_hold;
`else
    logic unused_dbg;

    assign unused_dbg  = ^{dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i};
    assign gnt_next    = GNT_CPU;
    assign start       = cpu_req_i;
    assign sel_we      = cpu_we_i;
    assign sel_addr    = cpu_addr_i;
    assign sel_wdata   = cpu_wdata_i;
    assign dbg_ack_o   = 1'b0;
    assign dbg_rdata_o = '0;
`endif

    // Access sequencer. The counter is loaded on entry to ACCESS and
    // DONE follows the ACCESS cycle in which it reads zero, so ACCESS
    // spans exactly MEM_LAT cycles and DONE lines up with read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt_q    <= GNT_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            en_q     <= 1'b0;
            cpu_hold <= '0;
        end else begin
            en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCESS;
                        cnt     <= CNT_LOAD;
                        gnt_q   <= gnt_next;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        en_q    <= 1'b1;   // strobe only in first ACCESS cycle
                    end
                end
                ACCESS: begin
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    if (cpu_done && !we_q)
                        cpu_hold <= mem_rdata_i;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_done    = (state == DONE) && (gnt_q == GNT_CPU);
    assign cpu_stall_o = cpu_req_i & ~cpu_done;
    assign cpu_rdata_o = cpu_done ? mem_rdata_i : cpu_hold;

    assign mem_en_o    = en_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Randomised and directed stimulus against a transaction-level model.
//   The model tracks each access by its grant cycle number: strobe at
//   grant+1, completion at grant+1+MEM_LAT, nothing in between.
//   Follows DMEM_ARB_DBG_EN the same way the design does.
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam bit CPU = 1'b0;
    localparam bit DBG = 1'b1;
`ifdef DMEM_ARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [DW-1:0] cpu_wdata_i = '0;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_stall_o;
    logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [AW-1:0] dbg_addr_i = '0;
    logic [DW-1:0] dbg_wdata_i = '0;
    logic [DW-1:0] dbg_rdata_o;
    logic          dbg_ack_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Memory environment: 64 words indexed by addr[5:0]; read data appears
    // exactly LAT cycles after the strobe, random garbage otherwise.
    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] rd_pipe [LAT];
    logic          pl_en = 1'b0;
    logic [5:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en_o && !mem_we_o) rd_pipe[0] <= env_mem[mem_addr_o[5:0]];
        else                       rd_pipe[0] <= $urandom;
        if (pl_en)                      env_mem[pl_addr] <= pl_data;
        else if (mem_en_o && mem_we_o)  env_mem[mem_addr_o[5:0]] <= mem_wdata_o;
    end
    assign mem_rdata_i = rd_pipe[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Reference model state
    int            cyc = 0;
    bit            busy = 0;
    int            g_cyc = 0;
    bit            who = 0;
    bit            t_we = 0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0;
    bit            last = DBG;
    logic [DW-1:0] cpu_hold_m = '0, dbg_hold_m = '0;
    logic [DW-1:0] ref_mem [64];
    bit            cpu_pend = 0, dbg_pend = 0;

    // Observations of the DUT, recorded each cycle
    bit            s_stall, s_en, s_ack;
    logic [DW-1:0] s_crd, s_drd;
    int            cpu_done_cyc = 0, ack_cyc = 0, en_cyc = 0, n_ack = 0, n_en = 0;
    bit            done_log [$];

    // One clock cycle: entered just after a negedge with inputs already set.
    task automatic run_cycle();
        bit en_e, dn, cdn, ddn, cfin, dfin, dr;
        logic [DW-1:0] ce, de;
        #1;
        cfin = 0; dfin = 0;
        s_stall = cpu_stall_o; s_en = mem_en_o; s_ack = dbg_ack_o;
        s_crd = cpu_rdata_o;   s_drd = dbg_rdata_o;
        if (s_en) begin en_cyc = cyc; n_en++; end
        if (s_ack) begin ack_cyc = cyc; n_ack++; done_log.push_back(DBG); end
        if (cpu_req_i && !s_stall) begin cpu_done_cyc = cyc; done_log.push_back(CPU); end
        if (rst) begin
            busy = 0; last = DBG; cpu_hold_m = '0; dbg_hold_m = '0;
            cfin = 1; dfin = 1;
        end else begin
            en_e = busy && (cyc == g_cyc + 1);
            dn   = busy && (cyc == g_cyc + 1 + LAT);
            cdn  = dn && (who == CPU);
            ddn  = dn && (who == DBG);
            chk("mem_en", s_en, en_e);
            if (en_e) begin
                chk("mem_we", mem_we_o, t_we);
                chk("mem_addr", mem_addr_o, t_addr);
                if (t_we) chk("mem_wdata", mem_wdata_o, t_wdata);
            end
            chk("cpu_stall", s_stall, cpu_req_i & ~cdn);
            chk("dbg_ack", s_ack, ddn);
            ce = cdn ? (t_we ? mem_rdata_i : ref_mem[t_addr[5:0]]) : cpu_hold_m;
            de = ddn ? (t_we ? mem_rdata_i : ref_mem[t_addr[5:0]]) : dbg_hold_m;
            if (!DBG_EN) de = '0;
            chk("cpu_rdata", s_crd, ce);
            chk("dbg_rdata", s_drd, de);
            if (dn) begin
                if (t_we)            ref_mem[t_addr[5:0]] = t_wdata;
                else if (who == CPU) cpu_hold_m = ref_mem[t_addr[5:0]];
                else                 dbg_hold_m = ref_mem[t_addr[5:0]];
                busy = 0; cfin = cdn; dfin = ddn;
            end else if (!busy) begin
                dr = DBG_EN && dbg_req_i;
                if (cpu_req_i || dr) begin
                    who   = (cpu_req_i && dr) ? ~last : dr;
                    last  = who;
                    busy  = 1;
                    g_cyc = cyc;
                    t_we    = who ? dbg_we_i    : cpu_we_i;
                    t_addr  = who ? dbg_addr_i  : cpu_addr_i;
                    t_wdata = who ? dbg_wdata_i : cpu_wdata_i;
                end
            end
        end
        cyc++;
        @(negedge clk);
        if (cfin) begin cpu_pend = 0; cpu_req_i = 1'b0; end
        if (dfin) begin dbg_pend = 0; dbg_req_i = 1'b0; end
    endtask

    task automatic cpu_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d; cpu_pend = 1;
    endtask

    task automatic dbg_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d; dbg_pend = 1;
    endtask

    // Reset for two cycles, loading one memory word meanwhile.
    task automatic reset_load(input logic [5:0] a, input logic [DW-1:0] d);
        rst = 1'b1;
        pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
        run_cycle();
        pl_en = 1'b0;
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((cpu_pend || dbg_pend) && k < 100) begin run_cycle(); k++; end
        if (k >= 100) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        bit            st [4];
        bit            en [4];
        logic [DW-1:0] rd;
        int            wd, k;

        @(negedge clk);
        // Fill memory with random contents while held in reset.
        for (int a = 0; a < 64; a++) begin
            pl_en = 1'b1; pl_addr = 6'(a); pl_data = $urandom; ref_mem[a] = pl_data;
            run_cycle();
        end
        pl_en = 1'b0;

        // Reset state
        reset_load(6'h10, 32'hDEAD_BEEF);
        #1;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_en", mem_en_o, 1'b0);
        chk("rst_ack", dbg_ack_o, 1'b0);
        chk("rst_crd", cpu_rdata_o, 32'h0);
        chk("rst_drd", dbg_rdata_o, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        @(negedge clk);

        // CPU read latency: stall 3 cycles, strobe in cycle 1, data in cycle 3
        cpu_issue(1'b0, 32'h10, '0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(); st[i] = s_stall; en[i] = s_en;
            if (i == 3) rd = s_crd;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_stall_c%0d", i), st[i], (i < 3));
            chk($sformatf("t1_en_c%0d", i), en[i], (i == 1));
        end
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        run_cycle();

        // Write then read back; read strobe two cycles after write DONE
        cpu_issue(1'b1, 32'h20, 32'h1234_5678);
        wait_idle("t2w");
        wd = cpu_done_cyc;
        cpu_issue(1'b0, 32'h20, '0);
        wait_idle("t2r");
        chk("t2_rdata", s_crd, 32'h1234_5678);
        chk("t2_gap", en_cyc - wd, 2);

        if (DBG_EN) begin
            // Simultaneous first requests: CPU first, dbg one access later
            reset_load(6'h30, 32'hA5A5_5A5A);
            done_log.delete(); n_ack = 0;
            cpu_issue(1'b0, 32'h10, '0);
            dbg_issue(1'b0, 32'h30, '0);
            wait_idle("t3");
            chk("t3_n_done", done_log.size(), 2);
            chk("t3_first", done_log[0], CPU);
            chk("t3_n_ack", n_ack, 1);
            chk("t3_ack_gap", ack_cyc - cpu_done_cyc, LAT + 2);
            chk("t3_drd", s_drd, 32'hA5A5_5A5A);

            // Both held continuously: completions alternate
            reset_load(6'h00, 32'h0);
            done_log.delete();
            k = 0;
            while (done_log.size() < 6 && k < 200) begin
                if (!cpu_pend) cpu_issue(1'b0, 32'($urandom_range(0, 63)), '0);
                if (!dbg_pend) dbg_issue(1'b1, 32'($urandom_range(0, 63)), $urandom);
                run_cycle(); k++;
            end
            if (k >= 200) chk("t4_timeout", 0, 1);
            for (int i = 0; i < 6 && i < done_log.size(); i++)
                chk($sformatf("t4_order%0d", i), done_log[i], bit'(i % 2));
            wait_idle("t4");
        end else begin
            // Debug held high in a CPU-only build: no effect at all
            reset_load(6'h10, 32'hDEAD_BEEF);
            n_en = 0; n_ack = 0;
            dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h30;
            cpu_issue(1'b0, 32'h10, '0);
            for (int i = 0; i < 4; i++) begin
                run_cycle(); st[i] = s_stall; en[i] = s_en;
                if (i == 3) rd = s_crd;
                dbg_req_i = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t3_stall_c%0d", i), st[i], (i < 3));
                chk($sformatf("t3_en_c%0d", i), en[i], (i == 1));
            end
            chk("t3_rdata", rd, 32'hDEAD_BEEF);
            for (int i = 0; i < 6; i++) begin run_cycle(); dbg_req_i = 1'b1; end
            chk("t3_n_en", n_en, 1);
            chk("t3_n_ack", n_ack, 0);
            dbg_req_i = 1'b0;
        end

        // Reset in the middle of a read: abandoned, late data not captured
        reset_load(6'h3C, 32'hCAFE_F00D);
        if (DBG_EN) dbg_issue(1'b0, 32'h3C, '0);
        else        cpu_issue(1'b0, 32'h3C, '0);
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk($sformatf("t5_ack_c%0d", i), s_ack, 1'b0);
            chk($sformatf("t5_drd_c%0d", i), s_drd, 32'h0);
            chk($sformatf("t5_crd_c%0d", i), s_crd, 32'h0);
            chk($sformatf("t5_en_c%0d", i), s_en, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (!cpu_pend && $urandom_range(0, 99) < 40)
                cpu_issue(1'($urandom), 32'($urandom), $urandom);
            if (DBG_EN) begin
                if (!dbg_pend && $urandom_range(0, 99) < 30)
                    dbg_issue(1'($urandom), 32'($urandom), $urandom);
                else if (dbg_pend && busy && who == DBG && $urandom_range(0, 3) == 0)
                    dbg_req_i = 1'b0;   // requester walks away; access completes anyway
            end else begin
                dbg_req_i = 1'($urandom); dbg_we_i = 1'($urandom);
                dbg_addr_i = $urandom; dbg_wdata_i = $urandom;
            end
            run_cycle();
        end
        if (!DBG_EN) dbg_req_i = 1'b0;
        wait_idle("rnd");
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
